// File: rtl/dac_write_sequencer_if.sv
// Producer-side handshake plus DAC pin bundle for dac_write_sequencer.
// slave = sequencer view, master = producer/board view.
interface dac_write_sequencer_if;
    logic       s_valid;
    logic [7:0] s_data;
    logic       s_ch;
    logic       s_ready;
    logic       AB;
    logic       CS;
    logic       WR;
    logic       LDAC;
    logic [7:0] D;
    logic       busy;
    logic       wr_done;

    modport slave (
        input  s_valid, s_data, s_ch,
        output s_ready, AB, CS, WR, LDAC, D, busy, wr_done
    );

    modport master (
        output s_valid, s_data, s_ch,
        input  s_ready, AB, CS, WR, LDAC, D, busy, wr_done
    );
endinterface

// File: rtl/dac_write_sequencer.sv
// Sample FIFO feeding a CS/WR/AB/D write-cycle generator for a dual 8-bit parallel DAC.
// Optional macro LDAC_SYNC_EN: hold LDAC high and pulse it low after each channel-B write.
//
// state  | meaning
// IDLE   | CS high; pop the FIFO head when one is queued
// SETUP  | CS low, AB/D stable, waiting SETUP_CYC before WR falls
// STROBE | WR low for WR_CYC cycles
// HOLD   | WR high, CS still low for HOLD_CYC cycles
// LOAD   | LDAC low for HOLD_CYC cycles after a channel-B write (LDAC_SYNC_EN only)
module dac_write_sequencer #(
    parameter int SETUP_CYC  = 2,
    parameter int WR_CYC     = 50,
    parameter int HOLD_CYC   = 30,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    dac_write_sequencer_if.slave    bus
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    typedef enum logic [2:0] {
        ST_IDLE, ST_SETUP, ST_STROBE, ST_HOLD, ST_LOAD
    } state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] count_q, count_d;
    logic          push, pop, s_ready;
    logic [8:0]    head;

    state_t        state_q, state_d;
    logic [7:0]    cnt_q, cnt_d;
    logic          cs_q, cs_d, wr_q, wr_d, ab_q, ab_d, done_q, done_d;
    logic [7:0]    d_q, d_d;

    // Full is judged from the registered count only, so a pop never frees a slot early.
    assign s_ready = (count_q != CW'(FIFO_DEPTH));
    assign push    = bus.s_valid && s_ready;
    assign pop     = (state_q == ST_IDLE) && (count_q != '0);
    assign head    = mem_q[rd_ptr_q];

    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= {bus.s_ch, bus.s_data};
    end

    always_comb begin
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
            count_q <= count_d;
        end
    end

`ifdef LDAC_SYNC_EN
    logic ldac_q, ldac_d;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            cs_q    <= 1'b1;
            wr_q    <= 1'b1;
            ab_q    <= 1'b0;
            d_q     <= '0;
            done_q  <= 1'b0;
`ifdef LDAC_SYNC_EN
            ldac_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            cs_q    <= cs_d;
            wr_q    <= wr_d;
            ab_q    <= ab_d;
            d_q     <= d_d;
            done_q  <= done_d;
`ifdef LDAC_SYNC_EN
            ldac_q  <= ldac_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (pop) state_d = ST_SETUP;
            ST_SETUP:  if (cnt_q == 8'(SETUP_CYC - 1)) state_d = ST_STROBE;
            ST_STROBE: if (cnt_q == 8'(WR_CYC - 1))    state_d = ST_HOLD;
            ST_HOLD: begin
                if (cnt_q == 8'(HOLD_CYC - 1)) begin
`ifdef LDAC_SYNC_EN
                    state_d = ab_q ? ST_LOAD : ST_IDLE;
`else
                    state_d = ST_IDLE;
`endif
                end
            end
            ST_LOAD:   if (cnt_q == 8'(HOLD_CYC - 1)) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
        cnt_d = (state_d != state_q || state_q == ST_IDLE) ? 8'd0 : cnt_q + 8'd1;
    end

    always_comb begin
        cs_d   = cs_q;
        wr_d   = wr_q;
        ab_d   = ab_q;
        d_d    = d_q;
        done_d = 1'b0;
`ifdef LDAC_SYNC_EN
        ldac_d = ldac_q;
`endif
        if (state_d != state_q) begin
            case (state_q)
                ST_IDLE: begin
                    cs_d = 1'b0;
                    ab_d = head[8];
                    d_d  = head[7:0];
                end
                ST_SETUP:  wr_d = 1'b0;
                ST_STROBE: wr_d = 1'b1;
                ST_HOLD: begin
                    cs_d   = 1'b1;
                    done_d = 1'b1;
`ifdef LDAC_SYNC_EN
                    if (ab_q) ldac_d = 1'b0;
`endif
                end
                ST_LOAD: begin
`ifdef LDAC_SYNC_EN
                    ldac_d = 1'b1;
`endif
                end
                default: ;
            endcase
        end
    end

    assign bus.s_ready = s_ready;
    assign bus.CS      = cs_q;
    assign bus.WR      = wr_q;
    assign bus.AB      = ab_q;
    assign bus.D       = d_q;
    assign bus.wr_done = done_q;
    assign bus.busy    = (state_q != ST_IDLE) || (count_q != '0);
`ifdef LDAC_SYNC_EN
    assign bus.LDAC    = ldac_q;
`else
    assign bus.LDAC    = 1'b0;
`endif
endmodule
